// File: rtl/uart_motor_pkg.sv
// rtl/uart_motor_pkg.sv - shared constants, frame layout and FSM type for the UART motor command path
package uart_motor_pkg;

   localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

   localparam logic [7:0] OP_SET_DUTY = 8'h01;
   localparam logic [7:0] OP_SET_DIR  = 8'h02;
   localparam logic [7:0] OP_ENABLE   = 8'h03;
   localparam logic [7:0] OP_ESTOP    = 8'h04;

   localparam int FIELD_W = 8;
   localparam int HDR_LSB = 24;
   localparam int OP_LSB  = 16;
   localparam int VAL_LSB = 8;
   localparam int CHK_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_APPLY,
      ST_REJECT
   } state_t;

   function automatic logic [FIELD_W-1:0] frame_field(input logic [31:0] frame, input int lsb);
      return frame[lsb +: FIELD_W];
   endfunction

   function automatic logic is_legal_op(input logic [7:0] op);
      return op inside {OP_SET_DUTY, OP_SET_DIR, OP_ENABLE, OP_ESTOP};
   endfunction

   // Checksum is the modulo-256 sum of the three leading bytes.
   function automatic logic [7:0] frame_sum(input logic [7:0] hdr, input logic [7:0] op,
                                            input logic [7:0] val);
      return hdr + op + val;
   endfunction

endpackage

// File: rtl/cmd_watchdog.sv
// rtl/cmd_watchdog.sv - command watchdog: counts while enabled, pulses trip when traffic ceases
module cmd_watchdog #(
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int WD_W           = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic trip
);

   logic [WD_W-1:0] count;

   // Trip on the edge at which the count would reach TIMEOUT_CYCLES-1; the counter restarts from 0.
   assign trip = enable && !clear && (count == WD_W'(TIMEOUT_CYCLES - 2));

   always_ff @(posedge clk) begin
      if (reset || !enable || clear || trip) begin
         count <= '0;
      end else begin
         count <= count + WD_W'(1);
      end
   end

endmodule

// File: rtl/uart_cmd_controller.sv
// rtl/uart_cmd_controller.sv - validates UART frames and applies motor duty/direction/enable commands
module uart_cmd_controller
   import uart_motor_pkg::*;
#(
   parameter logic [7:0] HEADER         = HEADER_DEFAULT,
   parameter logic [7:0] MAX_DUTY       = 8'd240,
   parameter int         TIMEOUT_CYCLES = 50_000_000,
   parameter int         WD_W           = 26
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic        Data_Ready,
   input  logic [31:0] Data,
   input  logic        Parity_ERR,
   output logic [7:0]  Duty,
   output logic        Dir,
   output logic        Motor_EN,
   output logic        Cmd_Valid,
   output logic        Cmd_Err,
   output logic [7:0]  Err_Count,
   output logic        Timeout
);

   state_t      state;
   logic        dr_q;
   logic [31:0] frame_q;
   logic        par_q;
   logic        ovr_pend;

   logic [7:0]  f_hdr, f_op, f_val, f_chk;
   logic        frame_event, ovr_evt, ovr_take;
   logic        frame_ok, dir_conflict, apply_ok, rej_now, wd_trip;
   logic [1:0]  err_inc;
   logic [8:0]  err_sum;

   assign f_hdr = frame_field(frame_q, HDR_LSB);
   assign f_op  = frame_field(frame_q, OP_LSB);
   assign f_val = frame_field(frame_q, VAL_LSB);
   assign f_chk = frame_field(frame_q, CHK_LSB);

   always_comb begin
      frame_event  = Data_Ready && !dr_q;
      ovr_evt      = frame_event && (state != ST_IDLE);
      frame_ok     = !par_q && (f_hdr == HEADER) && (f_chk == frame_sum(f_hdr, f_op, f_val))
                     && is_legal_op(f_op);
      // Reversing a powered, spinning bridge is refused rather than applied.
      dir_conflict = (state == ST_APPLY) && (f_op == OP_SET_DIR) && Motor_EN
                     && (Duty != '0) && (f_val[0] != Dir);
      apply_ok     = (state == ST_APPLY) && !dir_conflict;
      rej_now      = (state == ST_REJECT) || dir_conflict;
      // An overrun cannot share a cycle with Cmd_Valid, so it waits one cycle in ovr_pend.
      ovr_take     = (ovr_evt || ovr_pend) && !apply_ok;
      err_inc      = {1'b0, rej_now} + {1'b0, ovr_take};
      err_sum      = {1'b0, Err_Count} + {7'd0, err_inc};
   end

   cmd_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .WD_W          (WD_W)
   ) u_watchdog (
      .clk   (CLK),
      .reset (CLR),
      .enable(Motor_EN),
      .clear (apply_ok),
      .trip  (wd_trip)
   );

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state     <= ST_IDLE;
         dr_q      <= 1'b0;
         frame_q   <= '0;
         par_q     <= 1'b0;
         ovr_pend  <= 1'b0;
         Duty      <= '0;
         Dir       <= 1'b0;
         Motor_EN  <= 1'b0;
         Cmd_Valid <= 1'b0;
         Cmd_Err   <= 1'b0;
         Err_Count <= '0;
         Timeout   <= 1'b0;
      end else begin
         dr_q      <= Data_Ready;
         Cmd_Valid <= apply_ok;
         Cmd_Err   <= rej_now || ovr_take;
         ovr_pend  <= (ovr_evt || ovr_pend) && apply_ok;
         Err_Count <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];

         case (state)
            ST_IDLE: begin
               if (frame_event) begin
                  frame_q <= Data;
                  par_q   <= Parity_ERR;
                  state   <= ST_CHECK;
               end
            end
            ST_CHECK: state <= frame_ok ? ST_APPLY : ST_REJECT;
            default:  state <= ST_IDLE;
         endcase

         if (apply_ok) begin
            case (f_op)
               OP_SET_DUTY: Duty <= (f_val > MAX_DUTY) ? MAX_DUTY : f_val;
               OP_SET_DIR:  Dir  <= f_val[0];
               OP_ENABLE: begin
                  Motor_EN <= f_val[0];
                  if (f_val[0]) Timeout <= 1'b0;
               end
               OP_ESTOP: begin
                  Motor_EN <= 1'b0;
                  Duty     <= '0;
               end
               default: ;
            endcase
         end else if (wd_trip) begin
            Motor_EN <= 1'b0;
            Duty     <= '0;
            Timeout  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_controller.sv
// tb/tb_uart_cmd_controller.sv - self-checking bench for uart_cmd_controller with a behavioural model
module tb_uart_cmd_controller;

   localparam int T = 100;

   logic        CLK = 1'b0;
   logic        CLR, Data_Ready, Parity_ERR;
   logic [31:0] Data;
   logic [7:0]  Duty, Err_Count;
   logic        Dir, Motor_EN, Cmd_Valid, Cmd_Err, Timeout;

   int cyc = 0;
   int n_pass = 0;
   int n_total = 0;

   logic [7:0] m_duty, m_err;
   logic       m_dir, m_en, m_to;
   int         last_clear;
   logic       exp_v, exp_e;
   logic       obs_v, obs_e, obs_early;
   int         k_apply;

   uart_cmd_controller #(
      .HEADER        (8'hA5),
      .MAX_DUTY      (8'd240),
      .TIMEOUT_CYCLES(T),
      .WD_W          (8)
   ) dut (
      .CLK       (CLK),
      .CLR       (CLR),
      .Data_Ready(Data_Ready),
      .Data      (Data),
      .Parity_ERR(Parity_ERR),
      .Duty      (Duty),
      .Dir       (Dir),
      .Motor_EN  (Motor_EN),
      .Cmd_Valid (Cmd_Valid),
      .Cmd_Err   (Cmd_Err),
      .Err_Count (Err_Count),
      .Timeout   (Timeout)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic model_reset;
      m_duty = 8'd0; m_err = 8'd0; m_dir = 1'b0; m_en = 1'b0; m_to = 1'b0; last_clear = 0;
   endtask

   // Motor stops TIMEOUT_CYCLES-1 edges after the last accepted command if still enabled.
   task automatic wd_catchup(input int c);
      if (m_en && (c - last_clear >= T - 1)) begin
         m_en = 1'b0; m_duty = 8'd0; m_to = 1'b1;
      end
   endtask

   task automatic model_frame(input logic [31:0] d, input logic p, input int c);
      logic [7:0] h, o, v, s;
      h = d[31:24]; o = d[23:16]; v = d[15:8]; s = d[7:0];
      wd_catchup(c - 1);
      exp_v = 1'b0; exp_e = 1'b0;
      if (p || h != 8'hA5 || s != 8'((int'(h) + int'(o) + int'(v)) % 256) || o < 8'd1 || o > 8'd4)
         exp_e = 1'b1;
      else if (o == 8'd2 && m_en && m_duty != 8'd0 && v[0] != m_dir)
         exp_e = 1'b1;
      else begin
         exp_v = 1'b1;
         last_clear = c;
         case (o)
            8'd1: m_duty = (v > 8'd240) ? 8'd240 : v;
            8'd2: m_dir = v[0];
            8'd3: begin m_en = v[0]; if (v[0]) m_to = 1'b0; end
            default: begin m_en = 1'b0; m_duty = 8'd0; end
         endcase
      end
      if (exp_e) m_err = (m_err == 8'd255) ? 8'd255 : m_err + 8'd1;
      if (!exp_v) wd_catchup(c);
   endtask

   task automatic do_reset;
      @(negedge CLK); CLR = 1'b1; Data_Ready = 1'b0;
      repeat (2) @(negedge CLK);
      CLR = 1'b0;
      model_reset();
   endtask

   // Frame event at edge k; response sampled after edge k+2. Data_Ready held high for h cycles.
   task automatic send_frame(input logic [31:0] d, input logic p, input int h);
      int k;
      @(negedge CLK);
      Data = d; Parity_ERR = p; Data_Ready = 1'b1;
      k = cyc + 1;
      obs_early = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         if (i == h - 1) Data_Ready = 1'b0;
         if (i < 2) obs_early = obs_early | Cmd_Valid | Cmd_Err;
         else begin obs_v = Cmd_Valid; obs_e = Cmd_Err; end
      end
      k_apply = k + 2;
   endtask

   task automatic test_reset;
      CLR = 1'b1; Data_Ready = 1'b0; Data = '0; Parity_ERR = 1'b0;
      repeat (3) @(negedge CLK);
      n_total++; if ({Duty, Dir, Motor_EN} !== 10'd0) $display("FAIL reset_cfg: got duty=%0h dir=%0b en=%0b want 0", Duty, Dir, Motor_EN); else n_pass++;
      n_total++; if ({Cmd_Valid, Cmd_Err, Err_Count, Timeout} !== 11'd0) $display("FAIL reset_status: got v=%0b e=%0b cnt=%0d to=%0b want 0", Cmd_Valid, Cmd_Err, Err_Count, Timeout); else n_pass++;
      CLR = 1'b0;
      model_reset();
   endtask

   task automatic test_set_duty;
      send_frame(32'hA5_01_64_0A, 1'b0, 1); model_frame(32'hA5_01_64_0A, 1'b0, k_apply);
      n_total++; if (obs_early !== 1'b0 || obs_v !== 1'b1 || obs_e !== 1'b0) $display("FAIL duty_latency: got early=%0b v=%0b e=%0b want 0 1 0", obs_early, obs_v, obs_e); else n_pass++;
      n_total++; if (Duty !== 8'h64 || Err_Count !== 8'd0) $display("FAIL duty_first: got duty=%0h cnt=%0d want 64 0", Duty, Err_Count); else n_pass++;
      send_frame(32'hA5_01_FF_A5, 1'b0, 2); model_frame(32'hA5_01_FF_A5, 1'b0, k_apply);
      n_total++; if (Duty !== 8'd240 || obs_v !== 1'b1) $display("FAIL duty_clamp: got duty=%0d v=%0b want 240 1", Duty, obs_v); else n_pass++;
      send_frame(32'hA5_01_10_B6, 1'b0, 3); model_frame(32'hA5_01_10_B6, 1'b0, k_apply);
      n_total++; if (Duty !== 8'h10 || obs_v !== 1'b1 || obs_early !== 1'b0) $display("FAIL duty_hold3: got duty=%0h v=%0b early=%0b want 10 1 0", Duty, obs_v, obs_early); else n_pass++;
   endtask

   task automatic test_reject;
      logic [31:0] bad [3];
      logic        bad_p [3];
      bad[0] = 32'hA5_01_64_00; bad_p[0] = 1'b0;
      bad[1] = 32'hA5_01_64_0A; bad_p[1] = 1'b1;
      bad[2] = 32'h5A_01_64_0A; bad_p[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send_frame(bad[i], bad_p[i], 1); model_frame(bad[i], bad_p[i], k_apply);
         n_total++; if (obs_e !== 1'b1 || obs_v !== 1'b0 || obs_early !== 1'b0) $display("FAIL reject_%0d: got e=%0b v=%0b early=%0b want 1 0 0", i, obs_e, obs_v, obs_early); else n_pass++;
      end
      n_total++; if (Err_Count !== 8'd3 || Duty !== 8'h10) $display("FAIL reject_count: got cnt=%0d duty=%0h want 3 10", Err_Count, Duty); else n_pass++;
      for (int i = 0; i < 260; i++) begin
         logic [31:0] d;
         d = {8'h00, 24'($urandom)};
         send_frame(d, 1'($urandom), 1); model_frame(d, 1'b0, k_apply);
         n_total++; if (Err_Count !== m_err) $display("FAIL reject_sat_%0d: got cnt=%0d want %0d", i, Err_Count, m_err); else n_pass++;
      end
      n_total++; if (Err_Count !== 8'd255 || Duty !== 8'h10) $display("FAIL reject_saturate: got cnt=%0d duty=%0h want 255 10", Err_Count, Duty); else n_pass++;
   endtask

   task automatic test_dir_protect;
      send_frame(32'hA5_03_01_A9, 1'b0, 1); model_frame(32'hA5_03_01_A9, 1'b0, k_apply);
      send_frame(32'hA5_01_40_E6, 1'b0, 1); model_frame(32'hA5_01_40_E6, 1'b0, k_apply);
      send_frame(32'hA5_02_01_A8, 1'b0, 1); model_frame(32'hA5_02_01_A8, 1'b0, k_apply);
      n_total++; if (obs_e !== 1'b1 || obs_v !== 1'b0 || Dir !== 1'b0 || Motor_EN !== 1'b1) $display("FAIL dir_blocked: got e=%0b v=%0b dir=%0b en=%0b want 1 0 0 1", obs_e, obs_v, Dir, Motor_EN); else n_pass++;
      send_frame(32'hA5_04_00_A9, 1'b0, 1); model_frame(32'hA5_04_00_A9, 1'b0, k_apply);
      n_total++; if (Motor_EN !== 1'b0 || Duty !== 8'd0 || obs_v !== 1'b1) $display("FAIL estop: got en=%0b duty=%0h v=%0b want 0 0 1", Motor_EN, Duty, obs_v); else n_pass++;
      send_frame(32'hA5_02_01_A8, 1'b0, 1); model_frame(32'hA5_02_01_A8, 1'b0, k_apply);
      n_total++; if (obs_v !== 1'b1 || obs_e !== 1'b0 || Dir !== 1'b1) $display("FAIL dir_accept: got v=%0b e=%0b dir=%0b want 1 0 1", obs_v, obs_e, Dir); else n_pass++;
   endtask

   task automatic test_watchdog;
      int wait_n;
      send_frame(32'hA5_03_01_A9, 1'b0, 1); model_frame(32'hA5_03_01_A9, 1'b0, k_apply);
      send_frame(32'hA5_01_40_E6, 1'b0, 1); model_frame(32'hA5_01_40_E6, 1'b0, k_apply);
      wait_n = k_apply + T - 2 - cyc;
      repeat (wait_n) @(negedge CLK);
      n_total++; if (Motor_EN !== 1'b1 || Timeout !== 1'b0) $display("FAIL wd_early: got en=%0b to=%0b want 1 0", Motor_EN, Timeout); else n_pass++;
      @(negedge CLK);
      wd_catchup(cyc);
      n_total++; if (Motor_EN !== 1'b0 || Duty !== 8'd0 || Timeout !== 1'b1) $display("FAIL wd_trip: got en=%0b duty=%0h to=%0b want 0 0 1", Motor_EN, Duty, Timeout); else n_pass++;
      send_frame(32'hA5_03_01_A9, 1'b0, 1); model_frame(32'hA5_03_01_A9, 1'b0, k_apply);
      n_total++; if (Timeout !== 1'b0 || Motor_EN !== 1'b1) $display("FAIL wd_rearm: got to=%0b en=%0b want 0 1", Timeout, Motor_EN); else n_pass++;
      send_frame(32'hA5_04_00_A9, 1'b0, 1); model_frame(32'hA5_04_00_A9, 1'b0, k_apply);
   endtask

   task automatic test_overrun;
      do_reset();
      @(negedge CLK); Data = 32'hA5_01_64_0A; Parity_ERR = 1'b0; Data_Ready = 1'b1;
      @(negedge CLK); Data_Ready = 1'b0;
      @(negedge CLK); Data = 32'hA5_01_10_B6; Data_Ready = 1'b1;
      @(negedge CLK); Data_Ready = 1'b0;
      n_total++; if (Cmd_Valid !== 1'b1 || Cmd_Err !== 1'b0 || Duty !== 8'h64) $display("FAIL ovr_apply: got v=%0b e=%0b duty=%0h want 1 0 64", Cmd_Valid, Cmd_Err, Duty); else n_pass++;
      @(negedge CLK);
      n_total++; if (Cmd_Valid !== 1'b0 || Cmd_Err !== 1'b1 || Err_Count !== 8'd1) $display("FAIL ovr_drop: got v=%0b e=%0b cnt=%0d want 0 1 1", Cmd_Valid, Cmd_Err, Err_Count); else n_pass++;
      @(negedge CLK);
      n_total++; if (Cmd_Err !== 1'b0 || Duty !== 8'h64) $display("FAIL ovr_after: got e=%0b duty=%0h want 0 64", Cmd_Err, Duty); else n_pass++;
      @(negedge CLK); Data = 32'hA5_01_64_00; Data_Ready = 1'b1;
      @(negedge CLK); Data_Ready = 1'b0;
      @(negedge CLK); Data = 32'hA5_01_10_B6; Data_Ready = 1'b1;
      @(negedge CLK); Data_Ready = 1'b0;
      n_total++; if (Cmd_Err !== 1'b1 || Cmd_Valid !== 1'b0 || Err_Count !== 8'd3) $display("FAIL ovr_merge: got e=%0b v=%0b cnt=%0d want 1 0 3", Cmd_Err, Cmd_Valid, Err_Count); else n_pass++;
      @(negedge CLK);
      n_total++; if (Cmd_Err !== 1'b0 || Err_Count !== 8'd3 || Duty !== 8'h64) $display("FAIL ovr_merge_after: got e=%0b cnt=%0d duty=%0h want 0 3 64", Cmd_Err, Err_Count, Duty); else n_pass++;
   endtask

   task automatic test_clr_mid_frame;
      logic pulses;
      pulses = 1'b0;
      @(negedge CLK); Data = 32'hA5_03_01_A9; Parity_ERR = 1'b0; Data_Ready = 1'b1;
      @(negedge CLK); Data_Ready = 1'b0; CLR = 1'b1;
      @(negedge CLK); CLR = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pulses = pulses | Cmd_Valid | Cmd_Err;
         @(negedge CLK);
      end
      n_total++; if (pulses !== 1'b0) $display("FAIL clr_pulse: got pulse=%0b want 0", pulses); else n_pass++;
      n_total++; if ({Duty, Dir, Motor_EN, Err_Count, Timeout} !== 19'd0) $display("FAIL clr_state: got duty=%0h dir=%0b en=%0b cnt=%0d to=%0b want 0", Duty, Dir, Motor_EN, Err_Count, Timeout); else n_pass++;
      model_reset();
   endtask

   task automatic test_random;
      logic [7:0]  h, o, v, s;
      logic        p;
      logic [31:0] d;
      for (int i = 0; i < 60; i++) begin
         o = 8'($urandom_range(0, 5));
         v = 8'($urandom);
         h = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hA5;
         s = h + o + v;
         if ($urandom_range(0, 9) == 0) s = s ^ 8'($urandom_range(1, 255));
         p = ($urandom_range(0, 11) == 0);
         d = {h, o, v, s};
         if ($urandom_range(0, 9) == 0) repeat ($urandom_range(80, 120)) @(negedge CLK);
         else repeat ($urandom_range(0, 2)) @(negedge CLK);
         send_frame(d, p, int'($urandom_range(1, 3)));
         model_frame(d, p, k_apply);
         n_total++; if (obs_early !== 1'b0 || obs_v !== exp_v || obs_e !== exp_e) $display("FAIL rnd_pulse_%0d: got early=%0b v=%0b e=%0b want 0 %0b %0b frame=%h", i, obs_early, obs_v, obs_e, exp_v, exp_e, d); else n_pass++;
         n_total++; if (Duty !== m_duty) $display("FAIL rnd_duty_%0d: got %0h want %0h", i, Duty, m_duty); else n_pass++;
         n_total++; if (Dir !== m_dir || Motor_EN !== m_en) $display("FAIL rnd_dir_en_%0d: got dir=%0b en=%0b want %0b %0b", i, Dir, Motor_EN, m_dir, m_en); else n_pass++;
         n_total++; if (Err_Count !== m_err || Timeout !== m_to) $display("FAIL rnd_cnt_to_%0d: got cnt=%0d to=%0b want %0d %0b", i, Err_Count, Timeout, m_err, m_to); else n_pass++;
      end
      repeat (120) @(negedge CLK);
      wd_catchup(cyc);
      n_total++; if (Motor_EN !== m_en || Duty !== m_duty || Timeout !== m_to) $display("FAIL rnd_final: got en=%0b duty=%0h to=%0b want %0b %0h %0b", Motor_EN, Duty, Timeout, m_en, m_duty, m_to); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_set_duty();
      test_reject();
      test_dir_protect();
      test_watchdog();
      test_overrun();
      test_clr_mid_frame();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
